// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared constants, FSM state type and elaboration helper for
//                the sequential binary-to-BCD converter.
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    localparam int BCD_DIGIT_W       = 4;
    localparam int BCD_ADJ_THRESHOLD = 4;
    localparam int BCD_ADJ_OFFSET    = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } b2b_state_t;

    // 10**n, used to check at elaboration that NDIG digits can hold 2**W-1
    function automatic longint unsigned bcd_pow10(input int unsigned n);
        longint unsigned r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_adjust
//  Description : Double-dabble per-digit correction: add 3 to a 4-bit BCD
//                field when it exceeds 4, so the following left shift carries
//                correctly into the next decimal digit.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    localparam logic [BCD_DIGIT_W-1:0] C_THRESHOLD = BCD_DIGIT_W'(BCD_ADJ_THRESHOLD);
    localparam logic [BCD_DIGIT_W-1:0] C_OFFSET    = BCD_DIGIT_W'(BCD_ADJ_OFFSET);

    // Fields 5..9 become 8..12; 4-bit arithmetic never wraps for legal digits
    always_comb begin
        o_digit = i_digit;
        if (i_digit > C_THRESHOLD) begin
            o_digit = i_digit + C_OFFSET;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential binary-to-BCD converter (shift-and-add-3), one
//                binary bit per clock, with start/busy/done handshake. The
//                result register only updates on completion, so downstream
//                display logic never sees partial digits.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int W    = 8,
    parameter int NDIG = 3
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_start,
    input  logic [W-1:0]                i_bin,
    output logic                        o_busy,
    output logic                        o_done,
    output logic [BCD_DIGIT_W*NDIG-1:0] o_bcd
);

    localparam int SW = BCD_DIGIT_W*NDIG + W;   // scratch width
    localparam int BW = BCD_DIGIT_W*NDIG;       // BCD field width
    localparam int CW = $clog2(W+1);            // bit counter width

    // Reject digit counts too small to represent the largest operand
    if (!(bcd_pow10(NDIG) > ((64'd1 << W) - 64'd1))) begin : g_ndig_check
        $error("bin2bcd_seq: NDIG too small for W");
    end

    b2b_state_t    state_q,   state_d;
    logic [SW-1:0] scratch_q, scratch_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic          busy_q,    busy_d;
    logic          done_q,    done_d;
    logic [BW-1:0] bcd_q,     bcd_d;

    logic [SW-1:0] w_adj;
    logic [SW-1:0] w_shift;

    // Binary remainder passes through untouched; only digit fields are corrected
    assign w_adj[W-1:0] = scratch_q[W-1:0];

    for (genvar g = 0; g < NDIG; g++) begin : g_digit
        bcd_digit_adjust u_adj (
            .i_digit (scratch_q[W + BCD_DIGIT_W*g +: BCD_DIGIT_W]),
            .o_digit (w_adj    [W + BCD_DIGIT_W*g +: BCD_DIGIT_W])
        );
    end

    assign w_shift = w_adj << 1;

    // Next-state: load on accepted start, adjust-and-shift while converting
    always_comb begin
        state_d   = state_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bcd_d     = bcd_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d   = CONVERT;
                    scratch_d = {{BW{1'b0}}, i_bin};
                    cnt_d     = CW'(W);
                    busy_d    = 1'b1;
                end
            end
            CONVERT: begin
                scratch_d = w_shift;
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    // Last bit: publish the finished digits and free the FSM so
                    // a start in the done cycle is accepted without a gap
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    bcd_d   = w_shift[W +: BW];
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any conversion in flight
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
        end else begin
            state_q   <= state_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
        end
    end

    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_bcd  = bcd_q;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bin2bcd_seq
//  Description : Self-checking bench for bin2bcd_seq: directed vector table,
//                multi-cycle corner sequences and a shuffled full sweep
//                against a decimal-arithmetic reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;

    localparam int W    = 8;
    localparam int NDIG = 3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  bin   = 8'd0;
    logic        busy;
    logic        done;
    logic [11:0] bcd;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] bcd;
    } vec_t;

    bin2bcd_seq #(.W(W), .NDIG(NDIG)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_bin   (bin),
        .o_busy  (busy),
        .o_done  (done),
        .o_bcd   (bcd)
    );

    always #5 clk = ~clk;

    // Decimal digits computed with plain division
    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Present a start for exactly one accepting edge; returns #1 after it
    task automatic launch(input logic [7:0] v);
        start = 1'b1;
        bin   = v;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // From #1 after the accept edge, wait (bounded) for o_done. Counts busy
    // cycles, checks o_bcd keeps the old value meanwhile, optionally pokes a
    // second start at cycle 'poke' while busy.
    task automatic wait_done(input logic [11:0] hold, input int poke,
                             output int lat, output int busy_cnt, output int held_bad);
        lat      = 0;
        busy_cnt = int'(busy);
        held_bad = (bcd !== hold) ? 1 : 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == poke) begin
                start = 1'b1;
                bin   = 8'd17;
            end
            @(posedge clk);
            #1;
            if (k == poke) begin
                start = 1'b0;
                bin   = 8'h5A;
            end
            if (done) begin
                lat = k;
                break;
            end
            busy_cnt += int'(busy);
            if (bcd !== hold) held_bad++;
        end
    endtask

    initial begin
        vec_t        tbl[6];
        logic [11:0] prev;
        int          lat, bcnt, hbad, cnt;
        int          perm[256];

        tbl[0] = '{8'd255, 12'h255};
        tbl[1] = '{8'd0,   12'h000};
        tbl[2] = '{8'd99,  12'h099};
        tbl[3] = '{8'd100, 12'h100};
        tbl[4] = '{8'd9,   12'h009};
        tbl[5] = '{8'd10,  12'h010};

        // Reset state
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_bcd",  32'(bcd),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        prev = 12'h000;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            launch(tbl[i].bin);
            wait_done(prev, 0, lat, bcnt, hbad);
            check("tbl_bcd",     32'(bcd),  32'(tbl[i].bcd));
            check("tbl_latency", 32'(lat),  32'(W));
            check("tbl_busy",    32'(bcnt), 32'(W));
            check("tbl_hold",    32'(hbad), 32'd0);
            @(posedge clk);
            #1;
            check("tbl_done_width", 32'(done), 32'd0);
            prev = tbl[i].bcd;
        end

        // Start and operand changes while busy are ignored
        @(negedge clk);
        launch(8'd200);
        wait_done(prev, 3, lat, bcnt, hbad);
        check("ignore_bcd",     32'(bcd), 32'h200);
        check("ignore_latency", 32'(lat), 32'(W));
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done) cnt++;
        end
        check("ignore_extra_done", 32'(cnt), 32'd0);

        // Back-to-back: second start issued in the done cycle
        @(negedge clk);
        launch(8'd128);
        wait_done(12'h200, 0, lat, bcnt, hbad);
        check("b2b_first_bcd", 32'(bcd), 32'h128);
        launch(8'd64);
        wait_done(12'h128, 0, lat, bcnt, hbad);
        check("b2b_hold",       32'(hbad), 32'd0);
        check("b2b_second_bcd", 32'(bcd),  32'h064);
        check("b2b_latency",    32'(lat),  32'(W));

        // Asynchronous reset mid-conversion
        @(negedge clk);
        launch(8'd255);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_bcd",  32'(bcd),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (done) cnt++;
        end
        check("arst_no_done", 32'(cnt), 32'd0);
        check("arst_bcd_kept", 32'(bcd), 32'd0);

        // Shuffled sweep of every operand with random gaps (0 = back-to-back)
        for (int i = 0; i < 256; i++) perm[i] = i;
        for (int i = 255; i > 0; i--) begin
            int j, t;
            j = int'($urandom_range(0, i));
            t = perm[i];
            perm[i] = perm[j];
            perm[j] = t;
        end
        prev = 12'h000;
        for (int i = 0; i < 256; i++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            repeat (gap) @(posedge clk);
            #1;
            launch(8'(perm[i]));
            wait_done(prev, 0, lat, bcnt, hbad);
            check("sweep_bcd",     32'(bcd),  32'(ref_bcd(perm[i])));
            check("sweep_latency", 32'(lat),  32'(W));
            check("sweep_hold",    32'(hbad), 32'd0);
            prev = ref_bcd(perm[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
